// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared SIFT detection-chain types and constants
package sift_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_MAX  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Downstream blocks delay coordinates and valids by this many cycles.
  localparam int EXTREMA_LAT = 3;

  function automatic int num_groups(input int n);
    return (n + 8) / 9;
  endfunction

endpackage

// File: rtl/extrema_cmp_stage.sv
// rtl/extrema_cmp_stage.sv - centre vs one neighbour comparator slice
module extrema_cmp_stage #(
  parameter int DATA_W = 8,
  parameter int SIGNED = 0,
  parameter int STRICT = 1
) (
  input  logic [DATA_W-1:0] iCentre,
  input  logic [DATA_W-1:0] iNeigh,
  output logic              oGt,
  output logic              oLt
);

  // One extra bit lets a single signed compare cover both signednesses.
  logic signed [DATA_W:0] c_ext;
  logic signed [DATA_W:0] n_ext;

  assign c_ext = (SIGNED != 0) ? {iCentre[DATA_W-1], iCentre} : {1'b0, iCentre};
  assign n_ext = (SIGNED != 0) ? {iNeigh[DATA_W-1], iNeigh} : {1'b0, iNeigh};

  assign oGt = (STRICT != 0) ? (c_ext > n_ext) : (c_ext >= n_ext);
  assign oLt = (STRICT != 0) ? (c_ext < n_ext) : (c_ext <= n_ext);

endmodule

// File: rtl/extrema_detect_pipe.sv
// rtl/extrema_detect_pipe.sv - 3-stage 3x3x3 scale-space extrema detector
module extrema_detect_pipe
  import sift_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 0,
  parameter int NUM_NB = 26,
  parameter int STRICT = 1,
  parameter int TAG_W  = 20,
  parameter int CNT_W  = 16
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     iDval,
  input  logic [DATA_W-1:0]        iData_a,
  input  logic [NUM_NB*DATA_W-1:0] iNeigh,
  input  logic [DATA_W-1:0]        iThresh,
  input  logic [1:0]               iMode,
  input  logic [TAG_W-1:0]         iTag,
  input  logic                     iClr,
  output logic                     oDval,
  output logic                     oExtrema_en,
  output logic                     oIsMax,
  output logic                     oIsMin,
  output logic [TAG_W-1:0]         oTag,
  output logic [CNT_W-1:0]         oCount
);

  localparam int NG = num_groups(NUM_NB);

  if (!(NUM_NB == 8 || NUM_NB == 17 || NUM_NB == 26)) begin : g_bad_num_nb
    $error("extrema_detect_pipe: NUM_NB must be 8, 17 or 26");
  end

  logic [NUM_NB-1:0] gt_d;
  logic [NUM_NB-1:0] lt_d;

  for (genvar k = 0; k < NUM_NB; k++) begin : g_cmp
    extrema_cmp_stage #(
      .DATA_W(DATA_W),
      .SIGNED(SIGNED),
      .STRICT(STRICT)
    ) u_cmp (
      .iCentre(iData_a),
      .iNeigh (iNeigh[k*DATA_W +: DATA_W]),
      .oGt    (gt_d[k]),
      .oLt    (lt_d[k])
    );
  end

  // Extra bit so |most-negative| fits without wrapping.
  logic [DATA_W:0] mag_d;
  always_comb begin
    mag_d = {1'b0, iData_a};
    if (SIGNED != 0 && iData_a[DATA_W-1]) begin
      mag_d = ~{1'b1, iData_a} + (DATA_W+1)'(1);
    end
  end

  logic                v1_q;
  logic [NUM_NB-1:0]   gt1_q;
  logic [NUM_NB-1:0]   lt1_q;
  logic [DATA_W:0]     mag1_q;
  logic [DATA_W-1:0]   thr1_q;
  logic [1:0]          mode1_q;
  logic [TAG_W-1:0]    tag1_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= iDval;
    end
    gt1_q   <= gt_d;
    lt1_q   <= lt_d;
    mag1_q  <= mag_d;
    thr1_q  <= iThresh;
    mode1_q <= iMode;
    tag1_q  <= iTag;
  end

  logic [NG-1:0] gtp_d;
  logic [NG-1:0] ltp_d;
  logic          cok_d;

  always_comb begin
    gtp_d = '1;
    ltp_d = '1;
    for (int k = 0; k < NUM_NB; k++) begin
      gtp_d[k / 9] = gtp_d[k / 9] & gt1_q[k];
      ltp_d[k / 9] = ltp_d[k / 9] & lt1_q[k];
    end
    cok_d = mag1_q > {1'b0, thr1_q};
  end

  logic             v2_q;
  logic [NG-1:0]    gtp2_q;
  logic [NG-1:0]    ltp2_q;
  logic             cok2_q;
  logic [1:0]       mode2_q;
  logic [TAG_W-1:0] tag2_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
    end
    gtp2_q  <= gtp_d;
    ltp2_q  <= ltp_d;
    cok2_q  <= cok_d;
    mode2_q <= mode1_q;
    tag2_q  <= tag1_q;
  end

  logic is_max_d;
  logic is_min_d;

  always_comb begin
    is_max_d = (&gtp2_q) & cok2_q & ((mode2_q & MODE_MAX) != 2'b00);
    is_min_d = (&ltp2_q) & cok2_q & ((mode2_q & MODE_MIN) != 2'b00);
    // A flat neighbourhood satisfies both non-strict tests; it is not a keypoint.
    if (STRICT == 0 && is_max_d && is_min_d) begin
      is_max_d = 1'b0;
      is_min_d = 1'b0;
    end
  end

  logic             dval_q;
  logic             en_q;
  logic             max_q;
  logic             min_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      dval_q <= 1'b0;
      en_q   <= 1'b0;
      max_q  <= 1'b0;
      min_q  <= 1'b0;
      tag_q  <= '0;
    end else begin
      dval_q <= v2_q;
      if (v2_q) begin
        en_q  <= is_max_d | is_min_d;
        max_q <= is_max_d;
        min_q <= is_min_d;
        tag_q <= tag2_q;
      end
    end
  end

  logic             inc;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // A clear coinciding with an increment counts that extrema in the new frame.
  always_comb begin
    inc   = dval_q & en_q;
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oDval       = dval_q;
  assign oExtrema_en = en_q;
  assign oIsMax      = max_q;
  assign oIsMin      = min_q;
  assign oTag        = tag_q;
  assign oCount      = cnt_q;

endmodule

// File: tb/tb_extrema_detect_pipe.sv
// tb/tb_extrema_detect_pipe.sv - scoreboard bench for extrema_detect_pipe
module tb_extrema_detect_pipe;

  localparam int DW = 8;
  localparam int NB = 26;
  localparam int TW = 20;
  localparam int CW = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           dval;
  logic           clr;
  logic [DW-1:0]  data;
  logic [DW-1:0]  thr;
  logic [NB*DW-1:0] neigh;
  logic [1:0]     mode;
  logic [TW-1:0]  tag;

  logic           o_dval [NI];
  logic           o_en   [NI];
  logic           o_max  [NI];
  logic           o_min  [NI];
  logic [TW-1:0]  o_tag  [NI];
  logic [CW-1:0]  o_cnt  [NI];

  int cfg_signed [NI] = '{0, 1, 0};
  int cfg_strict [NI] = '{1, 0, 0};
  int cfg_nb     [NI] = '{26, 26, 17};

  extrema_detect_pipe #(.DATA_W(DW), .SIGNED(0), .NUM_NB(26), .STRICT(1), .TAG_W(TW), .CNT_W(CW)) u0 (
    .iclk(clk), .irst(rst), .iDval(dval), .iData_a(data), .iNeigh(neigh), .iThresh(thr),
    .iMode(mode), .iTag(tag), .iClr(clr), .oDval(o_dval[0]), .oExtrema_en(o_en[0]),
    .oIsMax(o_max[0]), .oIsMin(o_min[0]), .oTag(o_tag[0]), .oCount(o_cnt[0]));

  extrema_detect_pipe #(.DATA_W(DW), .SIGNED(1), .NUM_NB(26), .STRICT(0), .TAG_W(TW), .CNT_W(CW)) u1 (
    .iclk(clk), .irst(rst), .iDval(dval), .iData_a(data), .iNeigh(neigh), .iThresh(thr),
    .iMode(mode), .iTag(tag), .iClr(clr), .oDval(o_dval[1]), .oExtrema_en(o_en[1]),
    .oIsMax(o_max[1]), .oIsMin(o_min[1]), .oTag(o_tag[1]), .oCount(o_cnt[1]));

  extrema_detect_pipe #(.DATA_W(DW), .SIGNED(0), .NUM_NB(17), .STRICT(0), .TAG_W(TW), .CNT_W(CW)) u2 (
    .iclk(clk), .irst(rst), .iDval(dval), .iData_a(data), .iNeigh(neigh[17*DW-1:0]), .iThresh(thr),
    .iMode(mode), .iTag(tag), .iClr(clr), .oDval(o_dval[2]), .oExtrema_en(o_en[2]),
    .oIsMax(o_max[2]), .oIsMin(o_min[2]), .oTag(o_tag[2]), .oCount(o_cnt[2]));

  typedef struct {
    int unsigned   due;
    bit            en;
    bit            mx;
    bit            mn;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb [NI][$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s u%0d cyc=%0d got=%0h want=%0h", name, idx, cyc, act, want);
    end
  endtask

  function automatic int sval(input int idx, input logic [DW-1:0] v);
    if (cfg_signed[idx] != 0) return int'($signed(v));
    return int'(v);
  endfunction

  // Reference: centre must beat every neighbour, clear the threshold and be enabled by the mode.
  function automatic exp_t model(input int idx, input logic [DW-1:0] c, input logic [NB*DW-1:0] nb,
                                 input logic [DW-1:0] th, input logic [1:0] md);
    exp_t e;
    int   cv;
    int   nv;
    int   mag;
    bit   all_gt;
    bit   all_lt;
    bit   ok;
    cv     = sval(idx, c);
    all_gt = 1'b1;
    all_lt = 1'b1;
    for (int k = 0; k < cfg_nb[idx]; k++) begin
      nv = sval(idx, nb[k*DW +: DW]);
      if (cfg_strict[idx] != 0) begin
        if (!(cv > nv)) all_gt = 1'b0;
        if (!(cv < nv)) all_lt = 1'b0;
      end else begin
        if (!(cv >= nv)) all_gt = 1'b0;
        if (!(cv <= nv)) all_lt = 1'b0;
      end
    end
    mag  = (cv < 0) ? -cv : cv;
    ok   = mag > int'(th);
    e.mx = all_gt && ok && md[0];
    e.mn = all_lt && ok && md[1];
    if (cfg_strict[idx] == 0 && e.mx && e.mn) begin
      e.mx = 1'b0;
      e.mn = 1'b0;
    end
    e.en  = e.mx || e.mn;
    e.tag = '0;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [NB*DW-1:0] fill(input logic [DW-1:0] v);
    return {NB{v}};
  endfunction

  task automatic send(input logic [DW-1:0] c, input logic [NB*DW-1:0] nb, input logic [DW-1:0] th,
                      input logic [1:0] md, input logic [TW-1:0] tg, input bit cl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0; dval = 1'b1; data = c; neigh = nb; thr = th; mode = md; tag = tg; clr = cl;
    for (int i = 0; i < NI; i++) begin
      e     = model(i, c, nb, th, md);
      e.tag = tg;
      e.due = cyc + 3;
      sb[i].push_back(e);
    end
  endtask

  task automatic idle(input bit cl);
    @(posedge clk);
    #1;
    rst = 1'b0; dval = 1'b0; clr = cl;
    data = 8'($urandom); neigh = {7{32'($urandom)}}; tag = 20'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; dval = 1'b0; clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      while (sb[i].size() > 0 && sb[i][$].due > cyc) void'(sb[i].pop_back());
    end
  endtask

  initial begin : monitor
    bit            prev_rst;
    bit            prev_clr;
    bit            prev_inc [NI];
    int            exp_cnt  [NI];
    bit            h_en     [NI];
    bit            h_mx     [NI];
    bit            h_mn     [NI];
    logic [TW-1:0] h_tag    [NI];
    bit            inc;
    exp_t          e;
    prev_rst = 1'b1;
    prev_clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      prev_inc[i] = 1'b0; exp_cnt[i] = 0;
      h_en[i] = 1'b0; h_mx[i] = 1'b0; h_mn[i] = 1'b0; h_tag[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int i = 0; i < NI; i++) begin
          inc = 1'b0;
          if (prev_rst) begin
            exp_cnt[i] = 0;
            h_en[i] = 1'b0; h_mx[i] = 1'b0; h_mn[i] = 1'b0; h_tag[i] = '0;
          end else if (prev_clr) begin
            exp_cnt[i] = prev_inc[i] ? 1 : 0;
          end else if (prev_inc[i] && exp_cnt[i] < (1 << CW) - 1) begin
            exp_cnt[i]++;
          end
          if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
            e = sb[i].pop_front();
            check("dval", i, 32'(o_dval[i]), 32'd1);
            h_en[i] = e.en; h_mx[i] = e.mx; h_mn[i] = e.mn; h_tag[i] = e.tag;
            inc = e.en;
          end else begin
            check("dval", i, 32'(o_dval[i]), 32'd0);
          end
          check("extrema_en", i, 32'(o_en[i]), 32'(h_en[i]));
          check("is_max", i, 32'(o_max[i]), 32'(h_mx[i]));
          check("is_min", i, 32'(o_min[i]), 32'(h_mn[i]));
          check("tag", i, 32'(o_tag[i]), 32'(h_tag[i]));
          check("count", i, 32'(o_cnt[i]), 32'(exp_cnt[i]));
          prev_inc[i] = inc;
        end
        prev_rst = rst;
        prev_clr = clr;
      end
    end
  end

  initial begin : stimulus
    logic [NB*DW-1:0] nb;
    logic [DW-1:0]    c;
    logic [DW-1:0]    th;
    int               kind;
    rst = 1'b1; dval = 1'b0; clr = 1'b0; data = '0; neigh = '0; thr = '0; mode = 2'b00; tag = '0;
    repeat (3) @(posedge clk);

    send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'h12345, 1'b0);
    send(8'h80, fill(8'h9C), 8'd127, 2'b11, 20'h00001, 1'b0);
    send(8'h80, fill(8'h9C), 8'd128, 2'b11, 20'h00002, 1'b0);
    nb = fill(8'd40);
    nb[7:0] = 8'd50;
    send(8'd50, nb, 8'd5, 2'b11, 20'h00003, 1'b0);
    send(8'd50, fill(8'd50), 8'd5, 2'b11, 20'h00004, 1'b0);
    send(8'd200, fill(8'd100), 8'd10, 2'b10, 20'h00005, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send((i % 3 == 0) ? 8'd20 : 8'd200, fill(8'd100), 8'd10, (i % 2 == 0) ? 2'b01 : 2'b10,
           20'(i + 16), 1'b0);
    end
    repeat (4) idle(1'b0);

    idle(1'b1);
    for (int i = 0; i < 20; i++) send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'(i + 32), 1'b0);
    repeat (4) idle(1'b0);
    for (int i = 0; i < 6; i++) send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'(i + 64), i == 4);
    repeat (5) idle(1'b0);

    send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'h0AAAA, 1'b0);
    send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'h0BBBB, 1'b0);
    do_reset();
    repeat (2) idle(1'b0);
    send(8'd200, fill(8'd100), 8'd10, 2'b11, 20'h0CCCC, 1'b0);
    repeat (5) idle(1'b0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 15) == 0);
      end else begin
        c    = 8'($urandom);
        kind = $urandom_range(0, 3);
        for (int k = 0; k < NB; k++) begin
          case (kind)
            0:       nb[k*DW +: DW] = 8'($urandom);
            1:       nb[k*DW +: DW] = c - 8'($urandom_range(0, 3));
            2:       nb[k*DW +: DW] = c + 8'($urandom_range(0, 3));
            default: nb[k*DW +: DW] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : c;
          endcase
        end
        th = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
        send(c, nb, th, 2'($urandom), 20'($urandom), $urandom_range(0, 31) == 0);
      end
    end
    repeat (6) idle(1'b0);

    for (int i = 0; i < NI; i++) check("drain", i, 32'(sb[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
